// File: rtl/ext_mem_bridge.sv
// Bridges 32-bit core accesses onto a narrow strobe/ack pin bus: command, address,
// then write data or a turnaround and read data, with a per-beat ack timeout.
//
// state | meaning
// IDLE  | ready for a core request
// CMD   | one beat carrying the write flag and byte enables
// ADDR  | address beats, most-significant slice first
// WDATA | store data beats, least-significant slice first
// TURN  | one undriven cycle before the external side drives the pins
// RDATA | load data beats captured from pin_in, least-significant slice first
// RESP  | one-cycle completion pulse to the core
module ext_mem_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 24,
   parameter int PIN_WIDTH  = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [31:0]             req_address,
   input  logic [DATA_WIDTH-1:0]   req_write_data,
   input  logic [DATA_WIDTH/8-1:0] req_write_enable,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_read_data,
   output logic                    rsp_error,
   output logic [PIN_WIDTH-1:0]    pin_out,
   output logic [PIN_WIDTH-1:0]    pin_oe,
   input  logic [PIN_WIDTH-1:0]    pin_in,
   output logic                    pin_strobe,
   input  logic                    pin_ack
);

   localparam int NBE    = DATA_WIDTH / 8;
   localparam int ABEATS = ADDR_WIDTH / PIN_WIDTH;
   localparam int DBEATS = DATA_WIDTH / PIN_WIDTH;
   localparam int MAXB   = (ABEATS > DBEATS) ? ABEATS : DBEATS;
   localparam int BW     = (MAXB > 1) ? $clog2(MAXB) : 1;
   localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [BW-1:0] A_LAST = BW'(ABEATS - 1);
   localparam logic [BW-1:0] D_LAST = BW'(DBEATS - 1);
   localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_WDATA = 3'd3;
   localparam logic [2:0] S_TURN  = 3'd4;
   localparam logic [2:0] S_RDATA = 3'd5;
   localparam logic [2:0] S_RESP  = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [TW-1:0]         wait_q, wait_d;
   logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
   logic [DATA_WIDTH-1:0] wdata_sh_q, wdata_sh_d;
   logic [DATA_WIDTH-1:0] rdata_sh_q, rdata_sh_d;
   logic [NBE-1:0]        be_q, be_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;

   logic                  beat_active;
   logic                  drive_pins;
   logic [PIN_WIDTH-1:0]  cmd_beat;

   assign beat_active = (state_q == S_CMD) || (state_q == S_ADDR) ||
                        (state_q == S_WDATA) || (state_q == S_RDATA);
   assign drive_pins  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      wait_d     = wait_q;
      addr_sh_d  = addr_sh_q;
      wdata_sh_d = wdata_sh_q;
      rdata_sh_d = rdata_sh_q;
      be_d       = be_q;
      write_d    = write_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d    = S_CMD;
               addr_sh_d  = req_address[ADDR_WIDTH-1:0];
               wdata_sh_d = req_write_data;
               be_d       = req_write_enable;
               write_d    = |req_write_enable;
               beat_d     = '0;
               wait_d     = T_LOAD;
            end
         end
         S_CMD: begin
            if (pin_ack) begin
               state_d = S_ADDR;
               beat_d  = '0;
               wait_d  = T_LOAD;
            end
         end
         S_ADDR: begin
            if (pin_ack) begin
               addr_sh_d = addr_sh_q << PIN_WIDTH;
               wait_d    = T_LOAD;
               if (beat_q == A_LAST) begin
                  beat_d  = '0;
                  state_d = write_q ? S_WDATA : S_TURN;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_WDATA: begin
            if (pin_ack) begin
               wdata_sh_d = wdata_sh_q >> PIN_WIDTH;
               wait_d     = T_LOAD;
               if (beat_q == D_LAST) begin
                  state_d    = S_RESP;
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_TURN: begin
            state_d = S_RDATA;
            beat_d  = '0;
            wait_d  = T_LOAD;
         end
         S_RDATA: begin
            if (pin_ack) begin
               // shifting in from the top leaves the first beat in the low slice
               rdata_sh_d = {pin_in, rdata_sh_q[DATA_WIDTH-1:PIN_WIDTH]};
               wait_d     = T_LOAD;
               if (beat_q == D_LAST) begin
                  state_d    = S_RESP;
                  rsp_data_d = rdata_sh_d;
                  rsp_err_d  = 1'b0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (beat_active && !pin_ack) begin
         if (wait_q == '0) begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
         end else begin
            wait_d = wait_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         wait_q     <= '0;
         addr_sh_q  <= '0;
         wdata_sh_q <= '0;
         rdata_sh_q <= '0;
         be_q       <= '0;
         write_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         wait_q     <= wait_d;
         addr_sh_q  <= addr_sh_d;
         wdata_sh_q <= wdata_sh_d;
         rdata_sh_q <= rdata_sh_d;
         be_q       <= be_d;
         write_q    <= write_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_comb begin
      cmd_beat              = '0;
      cmd_beat[PIN_WIDTH-1] = write_q;
      cmd_beat[NBE-1:0]     = be_q;
      pin_out               = '0;
      case (state_q)
         S_CMD:   pin_out = cmd_beat;
         S_ADDR:  pin_out = addr_sh_q[ADDR_WIDTH-1 -: PIN_WIDTH];
         S_WDATA: pin_out = wdata_sh_q[PIN_WIDTH-1:0];
         default: pin_out = '0;
      endcase
   end

   assign pin_oe        = {PIN_WIDTH{drive_pins}};
   assign pin_strobe    = beat_active;
   assign req_ready     = (state_q == S_IDLE);
   assign rsp_valid     = (state_q == S_RESP);
   assign rsp_read_data = rsp_data_q;
   assign rsp_error     = rsp_err_q;

   logic unused_bits;
   if (ADDR_WIDTH < 32) begin : g_unused_hi
      assign unused_bits = ^{req_address[31:ADDR_WIDTH], rdata_sh_q[PIN_WIDTH-1:0]};
   end else begin : g_unused_lo
      assign unused_bits = ^rdata_sh_q[PIN_WIDTH-1:0];
   end

endmodule

// File: doc/ext_mem_bridge.md
Name: ext_mem_bridge

Overview:
Replaces the on-chip word memory behind the core with a narrow pin-level link to off-chip memory. Each 32-bit core access becomes a sequence of PIN_WIDTH-bit beats on the TinyTapeout bidirectional pins. Every beat is a strobe/ack handshake, and a per-beat timeout reports an error. The core stalls on req_ready and completes on rsp_valid.

Parameters:
DATA_WIDTH, 32, core word width; multiple of PIN_WIDTH.
ADDR_WIDTH, 24, low address bits sent off-chip; multiple of PIN_WIDTH.
PIN_WIDTH, 8, external bus width; must be >= 1 + DATA_WIDTH/8.
TIMEOUT, 255, maximum cycles a beat waits for pin_ack; must be >= 1.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core access request
req_ready  out  1  bridge accepts a request this cycle
req_address  in  32  byte address; bits [ADDR_WIDTH-1:0] are sent
req_write_data  in  DATA_WIDTH  store data
req_write_enable  in  DATA_WIDTH/8  byte enables; all zero means read
rsp_valid  out  1  one-cycle completion pulse
rsp_read_data  out  DATA_WIDTH  load data; valid with rsp_valid
rsp_error  out  1  timeout flag; valid with rsp_valid
pin_out  out  PIN_WIDTH  beat data driven off-chip
pin_oe  out  PIN_WIDTH  output enable; all ones or all zeros
pin_in  in  PIN_WIDTH  beat data from off-chip
pin_strobe  out  1  beat in progress
pin_ack  in  1  external completes the current beat

Behaviour:
- Reset (async, any state):
  - state goes to IDLE; in-flight transaction is dropped with no rsp_valid.
  - req_ready=1; rsp_valid=0, rsp_error=0, rsp_read_data=0.
  - pin_out=0, pin_oe=0, pin_strobe=0; internal counters cleared.
- States: IDLE, CMD, ADDR, WDATA, TURN, RDATA, RESP.
- IDLE:
  - req_ready=1; on req_valid, latch address, data and enables; go to CMD next cycle.
  - req_ready=0 in every other state.
- Beat handshake (CMD/ADDR/WDATA):
  - pin_strobe=1, pin_oe all ones, pin_out stable.
  - The beat completes on the edge where pin_ack=1; the next beat may start the following cycle with no gap.
  - pin_ack seen while pin_strobe=0 is ignored.
- CMD: a single beat. pin_out[PIN_WIDTH-1] = write (any enable bit set); pin_out[DATA_WIDTH/8-1:0] = enables; other bits 0.
- ADDR: ADDR_WIDTH/PIN_WIDTH beats, most-significant slice first. Then go to WDATA for writes, TURN for reads.
- WDATA: DATA_WIDTH/PIN_WIDTH beats, least-significant slice first (all slices sent regardless of enables). Then go to RESP.
- TURN: exactly one cycle with pin_oe=0 and pin_strobe=0, then go to RDATA.
- RDATA:
  - pin_oe=0, pin_strobe=1, DATA_WIDTH/PIN_WIDTH beats.
  - pin_in is captured on the ack edge, least-significant slice first. Then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_read_data = assembled word for reads, 0 for writes; rsp_error=0.
  - Next state IDLE.
  - rsp_read_data holds its value until the next RESP; rsp_error holds until the next RESP.
- Timeout:
  - The wait counter restarts at each beat start.
  - If pin_ack has not arrived after TIMEOUT strobed cycles, drop pin_strobe and pin_oe and go to RESP with rsp_error=1 and rsp_read_data=0.
  - Remaining beats are not sent.
- Request interface:
  - req_* inputs are sampled only at acceptance; later changes have no effect.
  - req_valid held high through RESP is accepted again in the next IDLE cycle, so back-to-back requests are 1 IDLE cycle apart.
- Minimum latency at defaults, acceptance edge to rsp_valid:
  - write: 8 beats + RESP = 9 cycles.
  - read: 4 beats + TURN + 4 beats + RESP = 10 cycles.
- Beat counter and slice index are sized with $clog2 from the parameters; no wrap-around beyond the beat count.

Test Plan:
- Write 0xDEADBEEF, enables 4'b1111, address 0x00012344, pin_ack tied 1 -> pin_out beats 0x8F,0x01,0x23,0x44,0xEF,0xBE,0xAD,0xDE; rsp_valid 9 cycles after acceptance; rsp_error=0.
- Read at address 0x000100; model returns 0x78,0x56,0x34,0x12 -> command beat 0x00; pin_oe=0 from the TURN cycle on; rsp_read_data=0x12345678.
- Read with pin_ack delayed 3 cycles per beat -> each beat's pin_out is held stable across the wait; rsp_valid at cycle 1+8×4+1 after acceptance.
- Read with pin_ack never asserted during the 2nd address beat, TIMEOUT=255 -> rsp_error=1 and rsp_read_data=0 after 255 strobed cycles; no further beats; req_ready=1 in the next cycle.
- Assert reset during WDATA beat 2 -> pin_strobe and pin_oe drop immediately (asynchronous); no rsp_valid; req_ready=1; a following read completes normally.
- Byte store of 0xAB at address 0x3, enables 4'b1000; then a second req_valid held through RESP -> command beat 0x88; second request accepted exactly 1 cycle after rsp_valid.
